// File: rtl/sync_fifo_v2_if.sv
// Producer/consumer handshake bundle for sync_fifo_v2.
// Carries overflow/underflow only when SYNC_FIFO_V2_ERR_EN is defined.
interface sync_fifo_v2_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
`ifdef SYNC_FIFO_V2_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_V2_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, almost_full, almost_empty, count
`ifdef SYNC_FIFO_V2_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO, any DEPTH >= 2, registered read data, count-derived flags.
// Define SYNC_FIFO_V2_ERR_EN to add sticky overflow/underflow indicators.
module sync_fifo_v2 #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3,
  parameter int unsigned AE_LEVEL = 1
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_v2_if.slave fifo_if
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full, empty;
  logic             wr_acc, rd_acc;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Acceptance uses the registered state, so an empty FIFO never bypasses din to dout.
  assign wr_acc = fifo_if.wr_en & ~full;
  assign rd_acc = fifo_if.rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= fifo_if.din;
    end
  end

  assign fifo_if.dout         = dout_q;
  assign fifo_if.full         = full;
  assign fifo_if.empty        = empty;
  assign fifo_if.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign fifo_if.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign fifo_if.count        = count_q;

`ifdef SYNC_FIFO_V2_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow_d  = overflow_q | (fifo_if.wr_en & full);
  assign underflow_d = underflow_q | (fifo_if.rd_en & empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo_if.overflow  = overflow_q;
  assign fifo_if.underflow = underflow_q;
`else
  // Without error tracking, rejected requests are dropped with no record.
`endif

endmodule
